// File: rtl/dot4s_pkg.sv
// Shared types and helpers for the signed dot-product accumulator.
// Optional feature macro used by the design files: SATURATE_EN.
package dot4s_pkg;

    localparam int PROD_W = 8;
    localparam int MAX_W  = 32;

    typedef enum logic {
        ACCUM,
        OUTPUT
    } state_e;

    // Sign-extend a product to the widest supported accumulator width;
    // callers truncate to their own ACC_W with a size cast.
    function automatic logic [MAX_W-1:0] sext(input logic [PROD_W-1:0] p);
        return {{(MAX_W-PROD_W){p[PROD_W-1]}}, p};
    endfunction

    // Largest positive value of a w-bit two's-complement number, in MAX_W bits.
    function automatic logic [MAX_W-1:0] acc_max(input int w);
        return (MAX_W'(1) << (w - 1)) - MAX_W'(1);
    endfunction

    // Most negative value of a w-bit two's-complement number; its low w bits
    // are the bitwise complement of acc_max.
    function automatic logic [MAX_W-1:0] acc_min(input int w);
        return ~acc_max(w);
    endfunction

endpackage

// File: rtl/dot4s_sat_add.sv
// ACC_W-bit two's-complement adder for the accumulator.
// With SATURATE_EN defined the result clamps to the ACC_W signed range and
// o_ovf flags the clamp; otherwise the add wraps and o_ovf is 0.
module dot4s_sat_add
    import dot4s_pkg::*;
#(
    parameter int ACC_W = 12
) (
    input  logic [ACC_W-1:0] i_a,
    input  logic [ACC_W-1:0] i_b,
    output logic [ACC_W-1:0] o_sum,
    output logic             o_ovf
);

    logic [ACC_W-1:0] w_raw;

    assign w_raw = i_a + i_b;

`ifdef SATURATE_EN
    logic w_ovf;

    // Overflow only when both operands share a sign the raw result lost.
    assign w_ovf = (i_a[ACC_W-1] == i_b[ACC_W-1]) && (w_raw[ACC_W-1] != i_a[ACC_W-1]);

    // Clamp toward the operands' sign on overflow.
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        o_sum = w_raw;
        if (w_ovf) begin
            o_sum = i_a[ACC_W-1] ? ACC_W'(acc_min(ACC_W)) : ACC_W'(acc_max(ACC_W));
        end
    end

    assign o_ovf = w_ovf;
`else
    assign o_sum = w_raw;
    assign o_ovf = 1'b0;
`endif

endmodule

// File: rtl/dot4s_accumulator.sv
// Signed dot-product accumulator: takes VEC_LEN 8-bit products over a
// valid/ready port and presents their ACC_W-bit sum on a second port.
// Optional feature macro: SATURATE_EN (clamping adds + sticky sat_o).
module dot4s_accumulator
    import dot4s_pkg::*;
#(
    parameter int VEC_LEN = 8,
    parameter int ACC_W   = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [PROD_W-1:0] prod_i,
    input  logic              prod_valid_i,
    output logic              prod_ready_o,
    output logic [ACC_W-1:0]  sum_o,
    output logic              sat_o,
    output logic              sum_valid_o,
    input  logic              sum_ready_i
);

    localparam int              CNT_W    = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(VEC_LEN - 1);

    state_e           r_state;
    state_e           w_state_nxt;
    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] r_sum;
    logic [CNT_W-1:0] r_cnt;
    logic             r_sat;
    logic             r_sat_out;
    logic [ACC_W-1:0] w_prod_ext;
    logic [ACC_W-1:0] w_add_sum;
    logic             w_add_ovf;
    logic             w_accept;
    logic             w_done;
    logic             w_last;

    assign w_prod_ext = ACC_W'(sext(prod_i));
    assign w_last     = (r_cnt == CNT_LAST);

    dot4s_sat_add #(
        .ACC_W (ACC_W)
    ) u_add (
        .i_a   (r_acc),
        .i_b   (w_prod_ext),
        .o_sum (w_add_sum),
        .o_ovf (w_add_ovf)
    );

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ACCUM;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and handshake outputs.
    always_comb begin
        w_state_nxt  = r_state;
        prod_ready_o = 1'b0;
        sum_valid_o  = 1'b0;
        w_accept     = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            ACCUM: begin
                prod_ready_o = 1'b1;
                w_accept     = prod_valid_i;
                if (prod_valid_i && w_last) begin
                    w_state_nxt = OUTPUT;
                end
            end
            OUTPUT: begin
                sum_valid_o = 1'b1;
                w_done      = sum_ready_i;
                if (sum_ready_i) begin
                    w_state_nxt = ACCUM;
                end
            end
            default: w_state_nxt = ACCUM;
        endcase
    end

    // Accumulator, element counter, sticky clamp flag and held result.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc     <= '0;
            r_cnt     <= '0;
            r_sat     <= 1'b0;
            r_sum     <= '0;
            r_sat_out <= 1'b0;
        end else if (w_accept) begin
            r_acc <= w_add_sum;
            r_cnt <= r_cnt + CNT_W'(1);
            r_sat <= r_sat | w_add_ovf;
            if (w_last) begin
                r_sum     <= w_add_sum;
                r_sat_out <= r_sat | w_add_ovf;
            end
        end else if (w_done) begin
            r_acc <= '0;
            r_cnt <= '0;
            r_sat <= 1'b0;
        end
    end

    // Result registers only load on the last accept, so they stay stable
    // for as long as the downstream stalls.
    assign sum_o = r_sum;
    assign sat_o = r_sat_out;

endmodule
